// File: rtl/sync_down_counter.sv
// Synchronous down counter / interval timer: T-flip-flop borrow chain plus an IDLE/RUN/DONE control FSM.
// Optional build macro SYNC_DOWN_COUNTER_AUTORELOAD_EN: reload from reload_reg on underflow instead of stopping.
module sync_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             en,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] reload_reg;
    logic             q_zero;
    logic             dec;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] q_dec;

    assign q_zero = (Q == ZERO);
    assign dec    = (state == RUN) && en && !q_zero;

    // Borrow chain: bit i toggles when every lower bit is already zero.
    always_comb begin
        t[0] = dec;
        for (int i = 1; i < WIDTH; i++) begin
            t[i] = t[i-1] & ~Q[i-1];
        end
        q_dec = Q ^ t;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Q          <= ZERO;
            reload_reg <= ZERO;
            state      <= IDLE;
            tc         <= 1'b0;
        end else if (load) begin
            Q          <= load_val;
            reload_reg <= load_val;
            state      <= IDLE;
            tc         <= 1'b0;
        end else begin
            tc <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= q_zero ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (q_zero) begin
`ifdef SYNC_DOWN_COUNTER_AUTORELOAD_EN
                        if (reload_reg == ZERO) begin
                            state <= DONE;
                        end else if (en) begin
                            Q <= reload_reg;
                        end
`else
                        state <= DONE;
`endif
                    end else if (dec) begin
                        Q  <= q_dec;
                        tc <= (Q == ONE);
                    end
                end
                DONE: begin
                    if (start) begin
                        Q <= reload_reg;
                        if (reload_reg != ZERO) begin
                            state <= RUN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_sync_down_counter.sv
// Scoreboard bench for sync_down_counter (WIDTH=4): driver pushes the expected {Q,busy,tc,done} per cycle, a monitor pops and compares.
// Build with SYNC_DOWN_COUNTER_AUTORELOAD_EN defined to exercise the autoreload expectations instead of the stop-at-zero ones.
module tb_sync_down_counter;

    localparam int WIDTH = 4;
    localparam int W     = WIDTH + 3;

    logic             clk;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             en;
    logic [WIDTH-1:0] Q;
    logic             busy;
    logic             tc;
    logic             done;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks   = 0;
    int           failures = 0;

    sync_down_counter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .en       (en),
        .Q        (Q),
        .busy     (busy),
        .tc       (tc),
        .done     (done)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        reset    = 1'b1;
        load     = 1'b0;
        load_val = '0;
        start    = 1'b0;
        en       = 1'b0;
    end

    // driver: inputs applied at negedge, expected post-edge outputs queued
    task automatic step(input logic r, input logic l, input logic [WIDTH-1:0] lv,
                        input logic s, input logic e,
                        input logic [WIDTH-1:0] eq, input logic eb, input logic et,
                        input logic ed, input string nm);
        @(negedge clk);
        reset    = r;
        load     = l;
        load_val = lv;
        start    = s;
        en       = e;
        #1;
        exp_q.push_back({eq, eb, et, ed});
        name_q.push_back(nm);
    endtask

    // monitor: outputs are valid every cycle, checked at negedge
    initial begin
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        string        nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                act_v = {Q, busy, tc, done};
                checks++;
                if (act_v !== exp_v) begin
                    failures++;
                    $display("FAIL %s: got Q=%0d busy=%b tc=%b done=%b, want Q=%0d busy=%b tc=%b done=%b",
                             nm, act_v[W-1:3], act_v[2], act_v[1], act_v[0],
                             exp_v[W-1:3], exp_v[2], exp_v[1], exp_v[0]);
                end
            end
        end
    end

    initial begin
        // reset for two cycles
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset_c1");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset_c2");

        // reset mid-RUN at Q=3
        step(0, 1, 5, 0, 0, 5, 0, 0, 0, "rst_mid_load");
        step(0, 0, 0, 1, 0, 5, 1, 0, 0, "rst_mid_start");
        step(0, 0, 0, 0, 1, 4, 1, 0, 0, "rst_mid_dec4");
        step(0, 0, 0, 0, 1, 3, 1, 0, 0, "rst_mid_dec3");
        step(1, 0, 0, 0, 1, 0, 0, 0, 0, "rst_mid_reset");
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, "rst_mid_after");

        // load 0 then start goes straight to DONE, no tc
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, "zero_load");
        step(0, 0, 0, 1, 1, 0, 0, 0, 1, "zero_start_done");

        // load and start on the same edge: load wins
        step(0, 1, 7, 1, 1, 7, 0, 0, 0, "load_start_same");
        step(0, 0, 0, 0, 1, 7, 0, 0, 0, "load_start_idle");

        // load mid-RUN aborts without tc
        step(0, 1, 4, 0, 0, 4, 0, 0, 0, "abort_load4");
        step(0, 0, 0, 1, 1, 4, 1, 0, 0, "abort_start");
        step(0, 0, 0, 0, 1, 3, 1, 0, 0, "abort_dec3");
        step(0, 1, 9, 0, 1, 9, 0, 0, 0, "abort_load9");
        step(0, 0, 0, 0, 1, 9, 0, 0, 0, "abort_idle");

`ifndef SYNC_DOWN_COUNTER_AUTORELOAD_EN
        // load 5, start, count to zero
        step(0, 1, 5, 0, 0, 5, 0, 0, 0, "cnt5_load");
        step(0, 0, 0, 1, 1, 5, 1, 0, 0, "cnt5_start");
        step(0, 0, 0, 0, 1, 4, 1, 0, 0, "cnt5_q4");
        step(0, 0, 0, 0, 1, 3, 1, 0, 0, "cnt5_q3");
        step(0, 0, 0, 0, 1, 2, 1, 0, 0, "cnt5_q2");
        step(0, 0, 0, 0, 1, 1, 1, 0, 0, "cnt5_q1");
        step(0, 0, 0, 0, 1, 0, 1, 1, 0, "cnt5_tc");
        step(0, 0, 0, 0, 1, 0, 0, 0, 1, "cnt5_done");
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 1, 0, 0, 0, 1, "cnt5_hold");
        end

        // enable gating and start ignored in RUN
        step(0, 1, 3, 0, 0, 3, 0, 0, 0, "gate_load");
        step(0, 0, 0, 1, 0, 3, 1, 0, 0, "gate_start");
        step(0, 0, 0, 0, 1, 2, 1, 0, 0, "gate_en1");
        step(0, 0, 0, 1, 0, 2, 1, 0, 0, "gate_en0_start");
        step(0, 0, 0, 0, 1, 1, 1, 0, 0, "gate_en1b");
        step(0, 0, 0, 0, 0, 1, 1, 0, 0, "gate_en0b");
        step(0, 0, 0, 0, 1, 0, 1, 1, 0, "gate_tc");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, "gate_done");

        // all-ones load: 15 decrements, no wrap
        step(0, 1, 15, 0, 0, 15, 0, 0, 0, "max_load");
        step(0, 0, 0, 1, 1, 15, 1, 0, 0, "max_start");
        for (int i = 14; i >= 1; i--) begin
            step(0, 0, 0, 0, 1, 4'(i), 1, 0, 0, "max_dec");
        end
        step(0, 0, 0, 0, 1, 0, 1, 1, 0, "max_tc");
        step(0, 0, 0, 0, 1, 0, 0, 0, 1, "max_done");
        step(0, 0, 0, 0, 1, 0, 0, 0, 1, "max_nowrap");

        // DONE restart from reload_reg
        step(0, 1, 2, 0, 0, 2, 0, 0, 0, "rs_load");
        step(0, 0, 0, 1, 1, 2, 1, 0, 0, "rs_start");
        step(0, 0, 0, 0, 1, 1, 1, 0, 0, "rs_q1");
        step(0, 0, 0, 0, 1, 0, 1, 1, 0, "rs_tc1");
        step(0, 0, 0, 0, 1, 0, 0, 0, 1, "rs_done1");
        step(0, 0, 0, 1, 0, 2, 1, 0, 0, "rs_restart");
        step(0, 0, 0, 0, 1, 1, 1, 0, 0, "rs_q1b");
        step(0, 0, 0, 0, 1, 0, 1, 1, 0, "rs_tc2");
        step(0, 0, 0, 0, 1, 0, 0, 0, 1, "rs_done2");
`else
        // autoreload: period 3, one tc per period, never DONE
        step(0, 1, 2, 0, 0, 2, 0, 0, 0, "ar_load");
        step(0, 0, 0, 1, 1, 2, 1, 0, 0, "ar_start");
        for (int p = 0; p < 4; p++) begin
            step(0, 0, 0, 0, 1, 1, 1, 0, 0, "ar_q1");
            step(0, 0, 0, 0, 1, 0, 1, 1, 0, "ar_tc");
            step(0, 0, 0, 0, 1, 2, 1, 0, 0, "ar_reload");
        end
        step(0, 0, 0, 0, 0, 2, 1, 0, 0, "ar_hold");
`endif

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
